// File: rtl/vending_change_dispenser.sv
// Change-return controller: pays a nickel-unit refund as one-at-a-time dime/nickel
// hopper commands while tracking coin inventory. Define CHANGE_TIMEOUT_EN for a hopper ack timeout.
module vending_change_dispenser #(
  parameter int CREDIT_W    = 6,
  parameter int INV_W       = 8,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 20,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [CREDIT_W-1:0] amount,
  input  logic                refill,
  input  logic [INV_W-1:0]    refill_nickels,
  input  logic [INV_W-1:0]    refill_dimes,
  input  logic                hopper_ack,
  output logic                N,
  output logic                D,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CREDIT_W-1:0] shortfall,
  output logic [INV_W-1:0]    nickel_cnt,
  output logic [INV_W-1:0]    dime_cnt,
  output logic                exact_change_only
);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    SELECT   = 4'b0010,
    DISPENSE = 4'b0100,
    DONE     = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic                n_q, n_d;
  logic                d_q, d_d;
  logic                err_q, err_d;
  logic [CREDIT_W-1:0] shortfall_q, shortfall_d;
  logic [CREDIT_W-1:0] remaining_q, remaining_d;
  logic [INV_W-1:0]    nickel_q, nickel_d;
  logic [INV_W-1:0]    dime_q, dime_d;

`ifdef CHANGE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[INV_W] ? '1 : sum[INV_W-1:0];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    n_d         = n_q;
    d_d         = d_q;
    err_d       = err_q;
    shortfall_d = shortfall_q;
    remaining_d = remaining_q;
    nickel_d    = nickel_q;
    dime_d      = dime_q;
`ifdef CHANGE_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (refill) begin
          nickel_d = sat_add(nickel_q, refill_nickels);
          dime_d   = sat_add(dime_q, refill_dimes);
        end else if (req) begin
          remaining_d = amount;
          shortfall_d = '0;
          err_d       = 1'b0;
          state_d     = SELECT;
        end
      end

      SELECT: begin
`ifdef CHANGE_TIMEOUT_EN
        timer_d = '0;
`endif
        // A nickel stands in for a dime once dimes run out.
        if (remaining_q >= CREDIT_W'(2) && dime_q != '0) begin
          d_d     = 1'b1;
          state_d = DISPENSE;
        end else if (remaining_q != '0 && nickel_q != '0) begin
          n_d     = 1'b1;
          state_d = DISPENSE;
        end else if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          err_d       = 1'b1;
          shortfall_d = remaining_q;
          state_d     = DONE;
        end
      end

      DISPENSE: begin
        if (hopper_ack) begin
          n_d     = 1'b0;
          d_d     = 1'b0;
          state_d = SELECT;
          if (d_q) begin
            dime_d      = dime_q - INV_W'(1);
            remaining_d = remaining_q - CREDIT_W'(2);
          end else begin
            nickel_d    = nickel_q - INV_W'(1);
            remaining_d = remaining_q - CREDIT_W'(1);
          end
        end
`ifdef CHANGE_TIMEOUT_EN
        // The un-acked coin stays counted in remaining and in inventory.
        else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          n_d         = 1'b0;
          d_d         = 1'b0;
          err_d       = 1'b1;
          shortfall_d = remaining_q;
          state_d     = DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end

      DONE: state_d = IDLE;

      default: begin
        n_d     = 1'b0;
        d_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= 1'b0;
      d_q         <= 1'b0;
      err_q       <= 1'b0;
      shortfall_q <= '0;
      remaining_q <= '0;
      nickel_q    <= INV_W'(NICKEL_INIT);
      dime_q      <= INV_W'(DIME_INIT);
`ifdef CHANGE_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      err_q       <= err_d;
      shortfall_q <= shortfall_d;
      remaining_q <= remaining_d;
      nickel_q    <= nickel_d;
      dime_q      <= dime_d;
`ifdef CHANGE_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign N                 = n_q;
  assign D                 = d_q;
  assign busy              = (state_q == SELECT) || (state_q == DISPENSE);
  assign done              = (state_q == DONE);
  assign err               = err_q;
  assign shortfall         = shortfall_q;
  assign nickel_cnt        = nickel_q;
  assign dime_cnt          = dime_q;
  assign exact_change_only = (nickel_q == '0);

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Directed bench for vending_change_dispenser: three instances cover default,
// no-dime and no-nickel inventories; timeout step applies when CHANGE_TIMEOUT_EN is defined.
module tb_vending_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       req [3];
  logic [5:0] amount [3];
  logic       refill [3];
  logic [7:0] rn [3];
  logic [7:0] rd [3];
  logic       ack [3];
  logic       n [3];
  logic       d [3];
  logic       busy [3];
  logic       done [3];
  logic       err [3];
  logic [5:0] short [3];
  logic [7:0] ncnt [3];
  logic [7:0] dcnt [3];
  logic       exact [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vending_change_dispenser u_dflt (
    .clk(clk), .rst(rst), .req(req[0]), .amount(amount[0]), .refill(refill[0]),
    .refill_nickels(rn[0]), .refill_dimes(rd[0]), .hopper_ack(ack[0]),
    .N(n[0]), .D(d[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .shortfall(short[0]), .nickel_cnt(ncnt[0]), .dime_cnt(dcnt[0]),
    .exact_change_only(exact[0]));

  vending_change_dispenser #(.DIME_INIT(0)) u_nodime (
    .clk(clk), .rst(rst), .req(req[1]), .amount(amount[1]), .refill(refill[1]),
    .refill_nickels(rn[1]), .refill_dimes(rd[1]), .hopper_ack(ack[1]),
    .N(n[1]), .D(d[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .shortfall(short[1]), .nickel_cnt(ncnt[1]), .dime_cnt(dcnt[1]),
    .exact_change_only(exact[1]));

  vending_change_dispenser #(.NICKEL_INIT(0), .DIME_INIT(1)) u_nonick (
    .clk(clk), .rst(rst), .req(req[2]), .amount(amount[2]), .refill(refill[2]),
    .refill_nickels(rn[2]), .refill_dimes(rd[2]), .hopper_ack(ack[2]),
    .N(n[2]), .D(d[2]), .busy(busy[2]), .done(done[2]), .err(err[2]),
    .shortfall(short[2]), .nickel_cnt(ncnt[2]), .dime_cnt(dcnt[2]),
    .exact_change_only(exact[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int i, input logic [5:0] amt);
    @(negedge clk);
    req[i]    = 1'b1;
    amount[i] = amt;
    @(negedge clk);
    req[i] = 1'b0;
    check($sformatf("u%0d busy after req", i), busy[i], 1);
  endtask

  task automatic expect_coin(input int i, input bit is_dime, input string tag);
    int w = 0;
    while (!(n[i] || d[i]) && w < 10) begin
      @(negedge clk);
      w++;
    end
    check({tag, " latency"}, w, 1);
    check({tag, " D"}, d[i], is_dime);
    check({tag, " N"}, n[i], !is_dime);
  endtask

  task automatic ack_coin(input int i, input string tag);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
    check({tag, " N|D low after ack"}, n[i] | d[i], 0);
  endtask

  task automatic expect_done(input int i, input bit exp_err, input logic [5:0] exp_short,
                             input bit req_in_done, input string tag);
    int w = 0;
    while (!done[i] && w < 10) begin
      @(negedge clk);
      w++;
    end
    check({tag, " done latency"}, w, 1);
    check({tag, " err"}, err[i], exp_err);
    check({tag, " shortfall"}, short[i], exp_short);
    if (req_in_done) req[i] = 1'b1;
    @(negedge clk);
    req[i] = 1'b0;
    check({tag, " done one cycle"}, done[i], 0);
    check({tag, " busy after done"}, busy[i], 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; amount[i] = 0; refill[i] = 0; rn[i] = 0; rd[i] = 0; ack[i] = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst N", n[0], 0);
    check("rst D", d[0], 0);
    check("rst busy", busy[0], 0);
    check("rst done", done[0], 0);
    check("rst err", err[0], 0);
    check("rst shortfall", short[0], 0);
    check("rst nickel_cnt", ncnt[0], 20);
    check("rst dime_cnt", dcnt[0], 20);
    check("rst exact u0", exact[0], 0);
    check("rst exact u2", exact[2], 1);

    // 35c from full inventory: D D D N.
    start_req(0, 6'd7);
    expect_coin(0, 1, "a7 c1"); ack_coin(0, "a7 c1");
    expect_coin(0, 1, "a7 c2"); ack_coin(0, "a7 c2");
    expect_coin(0, 1, "a7 c3"); ack_coin(0, "a7 c3");
    expect_coin(0, 0, "a7 c4"); ack_coin(0, "a7 c4");
    expect_done(0, 0, 6'd0, 0, "a7");
    check("a7 dime_cnt", dcnt[0], 17);
    check("a7 nickel_cnt", ncnt[0], 19);

    // No dimes: nickels substitute.
    start_req(1, 6'd3);
    expect_coin(1, 0, "nd c1"); ack_coin(1, "nd c1");
    expect_coin(1, 0, "nd c2"); ack_coin(1, "nd c2");
    expect_coin(1, 0, "nd c3"); ack_coin(1, "nd c3");
    expect_done(1, 0, 6'd0, 0, "nd");
    check("nd nickel_cnt", ncnt[1], 17);
    check("nd exact", exact[1], 0);

    // One dime, no nickels: 15c owed, 5c short.
    start_req(2, 6'd3);
    expect_coin(2, 1, "nn c1");
    check("nn exact mid", exact[2], 1);
    ack_coin(2, "nn c1");
    expect_done(2, 1, 6'd1, 0, "nn");
    check("nn dime_cnt", dcnt[2], 0);
    check("nn exact end", exact[2], 1);
    repeat (3) @(negedge clk);
    check("nn shortfall held", short[2], 1);

    // Reset while D waits for ack.
    start_req(0, 6'd2);
    expect_coin(0, 1, "rst c1");
    rst = 1'b1;
    #1;
    check("async rst D", d[0], 0);
    check("async rst busy", busy[0], 0);
    check("async rst dime_cnt", dcnt[0], 20);
    check("async rst nickel_cnt", ncnt[0], 20);
    @(negedge clk);
    rst = 1'b0;

    // Saturating refill.
    @(negedge clk);
    refill[0] = 1'b1; rn[0] = 8'd250; rd[0] = 8'd5;
    @(negedge clk);
    refill[0] = 1'b0;
    check("refill nickel sat", ncnt[0], 255);
    check("refill dime", dcnt[0], 25);

    // Refill beats a simultaneous req.
    refill[0] = 1'b1; rn[0] = 8'd0; rd[0] = 8'd0; req[0] = 1'b1; amount[0] = 6'd1;
    @(negedge clk);
    refill[0] = 1'b0; req[0] = 1'b0;
    check("req+refill busy", busy[0], 0);
    @(negedge clk);
    check("req+refill busy later", busy[0], 0);
    check("req+refill nickel", ncnt[0], 255);

    // Normal request after reset.
    start_req(0, 6'd2);
    expect_coin(0, 1, "post c1"); ack_coin(0, "post c1");
    expect_done(0, 0, 6'd0, 0, "post");
    check("post dime_cnt", dcnt[0], 24);

    // req pulses while busy and in DONE are ignored.
    start_req(0, 6'd1);
    expect_coin(0, 0, "ign c1");
    req[0] = 1'b1; amount[0] = 6'd9;
    @(negedge clk);
    check("ign N held", n[0], 1);
    ack_coin(0, "ign c1");
    expect_done(0, 0, 6'd0, 1, "ign");
    check("ign nickel_cnt", ncnt[0], 254);
    check("ign dime_cnt", dcnt[0], 24);

`ifdef CHANGE_TIMEOUT_EN
    begin
      int hi;
      start_req(0, 6'd2);
      expect_coin(0, 1, "to c1");
      hi = 1;
      while (d[0] && hi < 400) begin
        @(negedge clk);
        if (d[0]) hi++;
      end
      check("to D high cycles", hi, 255);
      check("to done", done[0], 1);
      check("to err", err[0], 1);
      check("to shortfall", short[0], 2);
      check("to dime_cnt", dcnt[0], 24);
      @(negedge clk);
      check("to done one cycle", done[0], 0);
    end
`else
    // Without the timeout the command is held indefinitely.
    start_req(0, 6'd2);
    expect_coin(0, 1, "hold c1");
    repeat (300) @(negedge clk);
    check("hold D", d[0], 1);
    check("hold busy", busy[0], 1);
    ack_coin(0, "hold c1");
    expect_done(0, 0, 6'd0, 0, "hold");
    check("hold dime_cnt", dcnt[0], 23);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
